branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Multi-cycle controller that executes conditional-branch instructions for the CPU core.
- Owns the architectural CVZN flags register.
- Accepts a branch request (condition code plus address of the branch opcode) and evaluates the 4-bit condition against the snapshotted flags.
- On a taken branch, fetches the target-address operand byte over a req/ack memory handshake; then issues a single-cycle PC write with either the target or the fall-through address.

Parameters:
ADDR_W, 8, program-counter / memory-address width
DATA_W, 8, memory data width; operand byte holding the branch target

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
flags_we  in  1  load flags register from flags_in
flags_in  in  4  new flags, packed {C,V,Z,N} (bit3=C, bit0=N)
flags_out  out  4  current flags register, same packing
br_valid  in  1  branch request present
br_ready  out  1  sequencer can accept a request
br_cccc  in  4  condition code of the request
br_pc  in  ADDR_W  address of the branch opcode byte
mem_req  out  1  operand read request
mem_addr  out  ADDR_W  operand read address
mem_ack  in  1  read data valid this cycle
mem_data  in  DATA_W  read data
pc_we  out  1  one-cycle PC write strobe
pc_out  out  ADDR_W  new PC value, valid while pc_we
done  out  1  one-cycle completion pulse, coincident with pc_we
taken  out  1  branch outcome, valid while done

Behaviour:
- Reset state: state IDLE, flags=0, mem_req=0, pc_we=0, done=0, taken=0. Also mem_addr=0, pc_out=0 and br_ready=1 in the cycle after rst deasserts.
- Flags register:
  - Loads flags_in on any cycle with flags_we=1, in every state.
  - flags_out reflects the register, not flags_in.
- States: IDLE, EVAL, FETCH, COMMIT.
- IDLE:
  - br_ready=1.
  - On br_valid & br_ready, latch cccc, pc and the flags snapshot, then go to EVAL.
  - The snapshot is the register value before any same-cycle flags_we write.
  - Flags writes after acceptance do not affect the in-flight branch.
- EVAL (br_ready=0):
  - Compute go = dcsn ^ cccc[0], where dcsn is selected by cccc[3:1]:
    - 0: Z
    - 1: C
    - 2: N
    - 3: V
    - 4: C & ~Z
    - 5: ~(N^V)
    - 6: ~Z & ~(N^V)
    - 7: 1
  - Code 7 with cccc[0]=1 is "never".
  - go=1 -> FETCH; go=0 -> COMMIT with taken=0.
- FETCH:
  - mem_req=1 and mem_addr=pc+1, modulo 2^ADDR_W (0xFF wraps to 0x00).
  - Holds until mem_ack; mem_ack is sampled only while mem_req=1.
  - Ack may arrive in the first FETCH cycle; a combinational ack path is allowed.
  - On ack, capture target = mem_data[ADDR_W-1:0]. Zero-extend if DATA_W<ADDR_W.
  - Then go to COMMIT with taken=1; mem_req drops the cycle after ack.
- COMMIT:
  - pc_we=1, done=1 and taken are driven for exactly one cycle.
  - pc_out = target if taken, else pc+2 modulo 2^ADDR_W.
  - Then IDLE; br_ready=1 the following cycle, with no back-to-back acceptance in COMMIT.
- Latency, with acceptance in cycle T:
  - Not taken: done at T+2.
  - Taken with zero-wait ack: done at T+3.
  - Each ack wait cycle adds 1.
- Unrelated inputs: br_valid/br_cccc/br_pc are ignored outside IDLE; mem_ack outside FETCH is ignored.
- Reset mid-operation:
  - rst in any state returns to IDLE next edge and clears the flags register.
  - mem_req, pc_we and done are 0 from the next cycle; no PC write is issued for the aborted branch.
  - A late mem_ack after reset is ignored.
- Outputs are registered or decoded from state only. No combinational path from br_valid to mem_req or pc_we.

Test Plan:
- Reset, then idle: flags_out=0, br_ready=1, pc_we=0 -> no strobes for 10 cycles.
- flags {C=0,V=0,Z=1,N=0}, cccc=0000 (Z), br_pc=0x10, ack zero-wait with mem_data=0x42 -> mem_addr=0x11; pc_we at T+3 with pc_out=0x42, taken=1.
- Same flags, cccc=0001 (not Z), br_pc=0x10 -> no mem_req; pc_we at T+2 with pc_out=0x12, taken=0.
- flags N=1,V=0, cccc=1010 (N==V): not taken -> pc_out=br_pc+2. Then N=1,V=1, cccc=1100, Z=0 -> taken.
- br_pc=0xFF, cccc=1110 (always), ack after 3 wait cycles, mem_data=0x05 -> mem_addr=0x00; mem_req held 4 cycles; pc_out=0x05 at T+6.
- Two checks on flags and reset:
  - flags_we in the acceptance cycle changes Z 1->0 with cccc=0000 -> outcome uses old Z (taken).
  - rst asserted during FETCH -> mem_req=0 next cycle, no pc_we, flags_out=0, br_ready=1.
- cccc=1111 (never) -> taken=0, pc_out=br_pc+2 regardless of flags.

Source files
------------

// File: rtl/branch_sequencer.sv
// branch_sequencer: conditional-branch controller; owns CVZN flags, evaluates
// cccc, fetches target byte over req/ack, issues a one-cycle PC write.
module branch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  output logic [3:0]        flags_out,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cccc,
  input  logic [ADDR_W-1:0] br_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_out,
  output logic              done,
  output logic              taken
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    FETCH,
    COMMIT
  } state_t;

  state_t state, nxt;

  logic [3:0]        flags;
  logic [3:0]        snap;
  logic [3:0]        cc;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pco_q;
  logic              tk_q;
  logic              dcsn;
  logic              go;
  logic [ADDR_W-1:0] tgt;

  generate
    if (DATA_W >= ADDR_W) begin : g_trunc
      assign tgt = mem_data[ADDR_W-1:0];
    end else begin : g_zext
      assign tgt = {{(ADDR_W-DATA_W){1'b0}}, mem_data};
    end
  endgenerate

  // snap packing: [3]=C [2]=V [1]=Z [0]=N
  always_comb begin
    dcsn = 1'b1;
    unique case (cc[3:1])
      3'd0: dcsn = snap[1];
      3'd1: dcsn = snap[3];
      3'd2: dcsn = snap[0];
      3'd3: dcsn = snap[2];
      3'd4: dcsn = snap[3] & ~snap[1];
      3'd5: dcsn = ~(snap[0] ^ snap[2]);
      3'd6: dcsn = ~snap[1] & ~(snap[0] ^ snap[2]);
      3'd7: dcsn = 1'b1;
    endcase
    go = dcsn ^ cc[0];
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (br_valid) nxt = EVAL;
      EVAL:   nxt = go ? FETCH : COMMIT;
      FETCH:  if (mem_ack) nxt = COMMIT;
      COMMIT: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      flags  <= 4'd0;
      snap   <= 4'd0;
      cc     <= 4'd0;
      pc_q   <= '0;
      addr_q <= '0;
      pco_q  <= '0;
      tk_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (flags_we) flags <= flags_in;
      unique case (state)
        IDLE: begin
          if (br_valid) begin
            cc     <= br_cccc;
            pc_q   <= br_pc;
            // old register value, ignoring a same-cycle write
            snap   <= flags;
            addr_q <= br_pc + ADDR_W'(1);
          end
        end
        EVAL: begin
          if (!go) begin
            pco_q <= pc_q + ADDR_W'(2);
            tk_q  <= 1'b0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            pco_q <= tgt;
            tk_q  <= 1'b1;
          end
        end
        COMMIT: ;
      endcase
    end
  end

  assign flags_out = flags;
  assign br_ready  = (state == IDLE);
  assign mem_req   = (state == FETCH);
  assign mem_addr  = addr_q;
  assign pc_we     = (state == COMMIT);
  assign done      = (state == COMMIT);
  assign pc_out    = pco_q;
  assign taken     = tk_q & (state == COMMIT);

endmodule
